uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, width of PRESCALE.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, holding-buffer entries (power of 2, >=2).
REQ-004 SHALL have port CLK  input  1  the single clock; all logic rises on CLK.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port P_DATA  input  DATA_WIDTH  byte to transmit.
REQ-007 SHALL have port DATA_VALID  input  1  P_DATA valid this cycle.
REQ-008 SHALL have port DATA_READY  output  1  buffer can accept; push = DATA_VALID & DATA_READY.
REQ-009 SHALL have ports PAR_EN, PAR_TYP, STOP2  input  1 each  parity enable, 0=even/1=odd, 1=two stop bits.
REQ-010 SHALL have port PRESCALE  input  PRESCALE_WIDTH  CLK cycles per bit.
REQ-011 SHALL have ports TX_OUT, BUSY, FRAME_DONE  output  1 each  serial line, frame in progress, one-cycle end-of-frame pulse.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL, in IDLE with buffer non-empty, pop the head entry and enter START on the next edge.
REQ-014 SHALL latch PAR_EN, PAR_TYP, STOP2, PRESCALE on the IDLE->START (or STOP->START) edge; changes mid-frame SHALL NOT affect the current frame.
REQ-015 SHALL treat PRESCALE=0 as 1; each bit SHALL last exactly the latched PRESCALE cycles.
REQ-016 SHALL drive TX_OUT 0 in START, data LSB first in DATA, parity in PARITY, 1 in STOP and IDLE.
REQ-017 SHALL skip PARITY when PAR_EN=0; parity bit = XOR of data (even) or XNOR of data (odd).
REQ-018 SHALL hold STOP one bit period (STOP2=0) or two (STOP2=1).
REQ-019 SHALL pulse FRAME_DONE high on the last CLK cycle of STOP.
REQ-020 SHALL, at end of STOP with buffer non-empty, pop and enter START directly with no idle cycle.
REQ-021 SHALL drive BUSY high in every state except IDLE.
REQ-022 SHALL drive DATA_READY = not full; a push when full is impossible by handshake.
REQ-023 SHALL allow simultaneous push and pop in one cycle, occupancy unchanged.
REQ-024 SHALL, on push into an empty buffer while IDLE, pop it the following cycle (latency data->START bit = 2 edges).
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.

Reset
REQ-026 SHALL, while RST=0 at a CLK edge, set state IDLE, TX_OUT=1, BUSY=0, FRAME_DONE=0, buffer empty, bit/cycle counters 0.
REQ-027 SHALL drive DATA_READY=0 while RST=0 and 1 on the first cycle after release.
REQ-028 SHALL, on reset mid-frame, abort the frame and discard buffered data; TX_OUT=1 from the next edge.

Structure
REQ-029 SHALL place the state enumeration and parity-type constants (EVEN=0, ODD=1) in shared package uart_pkg.
REQ-030 SHALL implement the holding buffer as sub-module uart_tx_fifo (synchronous, same CLK/RST).

Verification
REQ-031 SHALL cover: PRESCALE=32, PAR_EN=1, PAR_TYP=0, STOP2=0, push 0x5A -> TX_OUT 0,0,1,0,1,1,0,1,0,0,1 each 32 cycles; FRAME_DONE after 352 cycles.
REQ-032 SHALL cover: PAR_TYP=1, push 0x3F -> parity bit 1; PAR_EN=0, push 0x3F -> 10-bit frame, 320 cycles.
REQ-033 SHALL cover: STOP2=1, PRESCALE=8, push 0x58 then 0x01 -> second start bit immediately after 16 stop cycles, no idle gap, two FRAME_DONE pulses.
REQ-034 SHALL cover: while BUSY, push continuously -> exactly FIFO_DEPTH=4 accepted, then DATA_READY=0 until next pop.
REQ-035 SHALL cover: change PRESCALE 32->8 mid-frame -> current frame keeps 32-cycle bits; next frame uses 8.
REQ-036 SHALL cover: RST=0 during DATA bit 3 with 2 bytes buffered -> TX_OUT=1, BUSY=0 next edge, no further frames after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM states and parity types.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous holding buffer in front of the UART transmitter.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;

  // Advance read/write pointers; reset empties the buffer by aligning them.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage array is written on accepted pushes only and needs no reset.
  always_ff @(posedge CLK) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: buffered input, optional even/odd parity,
// one or two stop bits and a per-frame bit period latched at frame start.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  output logic                      DATA_READY,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY,
  output logic                      FRAME_DONE
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int PW    = PRESCALE_WIDTH;

  txState_t                state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [BIT_W-1:0]        bit_q;
  logic [PW-1:0]           cnt_q;
  logic [PW-1:0]           ps_q;
  logic                    parEn_q;
  logic                    parity_q;
  logic                    stop2_q;
  logic                    tx_q;
  logic                    busy_q;

  logic                    fifoPush;
  logic                    fifoPop;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic [DATA_WIDTH-1:0]   fifoData;

  logic [PW-1:0]           psIn;
  logic                    bitEnd;
  logic                    lastStop;
  logic                    frameEnd;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (fifoPush),
    .wdata_i (P_DATA),
    .pop_i   (fifoPop),
    .rdata_o (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign psIn     = (PRESCALE == '0) ? PW'(1) : PRESCALE;
  assign bitEnd   = (cnt_q == ps_q - PW'(1));
  assign lastStop = ~stop2_q | (bit_q == BIT_W'(1));
  assign frameEnd = (state_q == STOP) & bitEnd & lastStop;
  assign fifoPop  = ~fifoEmpty & ((state_q == IDLE) | frameEnd);
  assign fifoPush = DATA_VALID & DATA_READY;

  assign DATA_READY = RST & ~fifoFull;
  assign TX_OUT     = tx_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frameEnd;

  // Frame sequencer: a pop starts a new frame and latches its configuration,
  // otherwise each bit period ends by moving to the next bit or state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      ps_q     <= PW'(1);
      parEn_q  <= 1'b0;
      parity_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else if (fifoPop) begin
      state_q  <= START;
      shift_q  <= fifoData;
      parity_q <= (^fifoData) ^ (PAR_TYP == ODD);
      parEn_q  <= PAR_EN;
      stop2_q  <= STOP2;
      ps_q     <= psIn;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b0;
      busy_q   <= 1'b1;
    end else if (state_q != IDLE) begin
      if (!bitEnd) begin
        cnt_q <= cnt_q + PW'(1);
      end else begin
        cnt_q <= '0;
        case (state_q)
          START: begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
          DATA: begin
            if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
              bit_q <= '0;
              if (parEn_q) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
          PARITY: begin
            state_q <= STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
          STOP: begin
            if (!lastStop) begin
              bit_q <= BIT_W'(1);
            end else begin
              state_q <= IDLE;
              bit_q   <= '0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg with hand-computed frame patterns.
// Frame patterns are packed so that bit k is the k-th bit on the line (start first).
module tb_uart_tx_cfg;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [5:0] PRESCALE;
  logic       TX_OUT;
  logic       BUSY;
  logic       FRAME_DONE;

  int testCount;
  int failCount;

  uart_tx_cfg #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6),
    .FIFO_DEPTH     (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Offer one byte at a negedge, wait (bounded) for acceptance, return at the following negedge.
  task automatic applyStimulus(input logic [7:0] data);
    int guard;
    guard = 0;
    P_DATA     = data;
    DATA_VALID = 1'b1;
    while (!DATA_READY && guard < 1000) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 1000) checkOutput("push timeout", 32'(DATA_READY), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  // Count negedges until the line shows a start bit (bounded).
  task automatic waitStart(output int waited);
    waited = 0;
    while (TX_OUT !== 1'b0 && waited < 1000) begin
      @(negedge CLK);
      waited++;
    end
  endtask

  // Called on the first negedge of a start bit; samples each bit mid-period and times FRAME_DONE.
  task automatic checkFrame(input string tag, input int ps, input int nbits, input logic [15:0] expBits);
    int total;
    int doneAt;
    total  = ps * nbits;
    doneAt = -1;
    for (int i = 0; i < total + 4; i++) begin
      if (i > 0) @(negedge CLK);
      if ((i % ps) == (ps / 2) && (i / ps) < nbits)
        checkOutput($sformatf("%s bit%0d", tag, i / ps), 32'(TX_OUT), 32'(expBits[i / ps]));
      if (i == ps / 2) checkOutput({tag, " busy"}, 32'(BUSY), 32'd1);
      if (FRAME_DONE === 1'b1) begin
        doneAt = i;
        break;
      end
    end
    checkOutput({tag, " len"}, 32'(doneAt + 1), 32'(total));
  endtask

  // One negedge after a frame: line idle, not busy, done pulse gone.
  task automatic idleCheck(input string tag);
    @(negedge CLK);
    checkOutput({tag, " idle busy"}, 32'(BUSY), 32'd0);
    checkOutput({tag, " idle tx"}, 32'(TX_OUT), 32'd1);
    checkOutput({tag, " idle done"}, 32'(FRAME_DONE), 32'd0);
  endtask

  task automatic doReset(input int cycles);
    RST = 1'b0;
    repeat (cycles) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int waited;
    int accepted;
    int busyCnt;
    int lowCnt;
    testCount  = 0;
    failCount  = 0;
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    PRESCALE   = 6'd32;

    // Reset state
    repeat (3) @(negedge CLK);
    checkOutput("rst tx", 32'(TX_OUT), 32'd1);
    checkOutput("rst busy", 32'(BUSY), 32'd0);
    checkOutput("rst done", 32'(FRAME_DONE), 32'd0);
    checkOutput("rst ready", 32'(DATA_READY), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("rel ready", 32'(DATA_READY), 32'd1);

    // 0x5A, even parity, 32-cycle bits, one stop bit
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd32;
    applyStimulus(8'h5A);
    waitStart(waited);
    checkOutput("5A latency", 32'(waited), 32'd1);
    checkFrame("f5A", 32, 11, 16'h04B4);
    idleCheck("f5A");

    // 0x3F, odd parity, then parity disabled
    PAR_TYP = 1'b1;
    applyStimulus(8'h3F);
    waitStart(waited);
    checkFrame("f3Fodd", 32, 11, 16'h067E);
    idleCheck("f3Fodd");
    PAR_EN = 1'b0;
    applyStimulus(8'h3F);
    waitStart(waited);
    checkFrame("f3Fnp", 32, 10, 16'h027E);
    idleCheck("f3Fnp");

    // PRESCALE of zero behaves as one cycle per bit
    PRESCALE = 6'd0;
    applyStimulus(8'h3F);
    waitStart(waited);
    checkFrame("ps0", 1, 10, 16'h027E);
    idleCheck("ps0");

    // Two stop bits, back-to-back frames without idle gap
    PAR_EN = 1'b0; STOP2 = 1'b1; PRESCALE = 6'd8;
    applyStimulus(8'h58);
    applyStimulus(8'h01);
    waitStart(waited);
    checkFrame("f58", 8, 11, 16'h06B0);
    waitStart(waited);
    checkOutput("b2b gap", 32'(waited), 32'd1);
    checkFrame("f01", 8, 11, 16'h0602);
    idleCheck("f01");

    // PRESCALE change mid-frame only affects the following frame
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd32;
    applyStimulus(8'h5A);
    applyStimulus(8'h01);
    waitStart(waited);
    PRESCALE = 6'd8;
    checkFrame("psA", 32, 11, 16'h04B4);
    waitStart(waited);
    checkOutput("ps gap", 32'(waited), 32'd1);
    checkFrame("psB", 8, 11, 16'h0602);
    idleCheck("psB");

    // Continuous pushes while busy: exactly four accepted
    PAR_EN = 1'b0; PRESCALE = 6'd8;
    applyStimulus(8'h11);
    @(negedge CLK);
    checkOutput("fill started", 32'(BUSY), 32'd1);
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      P_DATA     = 8'(8'h20 + i);
      DATA_VALID = 1'b1;
      if (DATA_READY) accepted++;
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    checkOutput("fill accepted", 32'(accepted), 32'd4);
    checkOutput("fill ready", 32'(DATA_READY), 32'd0);
    waited = 0;
    while (FRAME_DONE !== 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("fill done seen", 32'(FRAME_DONE), 32'd1);
    checkOutput("fill ready at done", 32'(DATA_READY), 32'd0);
    @(negedge CLK);
    checkOutput("fill ready after pop", 32'(DATA_READY), 32'd1);
    doReset(2);

    // Reset during data bit 3 with two bytes buffered
    PAR_EN = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd8;
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    repeat (34) @(negedge CLK);
    checkOutput("abort in bit3", 32'(TX_OUT), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("abort tx", 32'(TX_OUT), 32'd1);
    checkOutput("abort busy", 32'(BUSY), 32'd0);
    checkOutput("abort ready", 32'(DATA_READY), 32'd0);
    checkOutput("abort done", 32'(FRAME_DONE), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abort rel ready", 32'(DATA_READY), 32'd1);
    busyCnt = 0;
    lowCnt  = 0;
    for (int i = 0; i < 200; i++) begin
      if (BUSY) busyCnt++;
      if (!TX_OUT) lowCnt++;
      @(negedge CLK);
    end
    checkOutput("abort no busy", 32'(busyCnt), 32'd0);
    checkOutput("abort line high", 32'(lowCnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
